// File: rtl/sdram_para.sv
// Shared encodings for the SDRAM controller: arbiter states and SDRAM command words.
package sdram_para;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } arb_state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PREGE = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;

  localparam logic [11:0] PREGE_ALL_ADDR = 12'h400;

endpackage

// File: rtl/sdram_arb_pick.sv
// Fixed-priority pick over {ref, wr, rd}; returns a one-hot winner, zero when idle.
module sdram_arb_pick (
  input  logic [2:0] rq,
  output logic [2:0] win
);

  always_comb begin
    win = 3'b000;
    if (rq[2])      win = 3'b100;
    else if (rq[1]) win = 3'b010;
    else if (rq[0]) win = 3'b001;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init sequencing, then per-transaction grants to refresh/write/read.
// Optional grant timeout with sticky arb_tout output under SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
  import sdram_para::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BA_WIDTH   = 2,
  parameter int CMD_WIDTH  = 4,
  parameter int TOUT_CYC   = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic [CMD_WIDTH-1:0]  init_cmd,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic                  ref_rq,
  input  logic                  ref_end,
  input  logic [CMD_WIDTH-1:0]  ref_cmd,
  output logic                  ref_en,
  input  logic                  wr_rq,
  input  logic                  wr_end_flag,
  input  logic [CMD_WIDTH-1:0]  wr_cmd,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BA_WIDTH-1:0]   wr_bank_addr,
  output logic                  wr_en,
  input  logic                  rd_rq,
  input  logic                  rd_end_flag,
  input  logic [CMD_WIDTH-1:0]  rd_cmd,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BA_WIDTH-1:0]   rd_bank_addr,
  output logic                  rd_en,
  output logic [CMD_WIDTH-1:0]  sdram_cmd,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [BA_WIDTH-1:0]   sdram_ba,
  output logic                  arb_busy
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,
  output logic                  arb_tout
`endif
);

  localparam logic [ADDR_WIDTH-1:0] A10_ADDR = ADDR_WIDTH'(PREGE_ALL_ADDR);

  arb_state_t state;
  logic [2:0] win;
  logic       tout_hit;

  sdram_arb_pick u_pick (
    .rq  ({ref_rq, wr_rq, rd_rq}),
    .win (win)
  );

  assign arb_busy = (state == S_AREF) || (state == S_WRITE) || (state == S_READ);

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [9:0] tout_cnt;

  assign tout_hit = arb_busy && (tout_cnt == 10'(TOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_cnt <= '0;
      arb_tout <= 1'b0;
    end else begin
      if (state == S_ARBIT)           tout_cnt <= '0;
      else if (arb_busy && !tout_hit) tout_cnt <= tout_cnt + 10'd1;
      if (tout_hit) arb_tout <= 1'b1;
    end
  end
`else
  assign tout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_INIT;
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
    end else begin
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
      case (state)
        S_INIT:  if (init_end) state <= S_ARBIT;
        S_ARBIT: begin
          // grant pulse lands on the first cycle of the new state
          if (win[2]) begin
            state  <= S_AREF;
            ref_en <= 1'b1;
          end else if (win[1]) begin
            state <= S_WRITE;
            wr_en <= 1'b1;
          end else if (win[0]) begin
            state <= S_READ;
            rd_en <= 1'b1;
          end
        end
        S_AREF:  if (ref_end || tout_hit)     state <= S_ARBIT;
        S_WRITE: if (wr_end_flag || tout_hit) state <= S_ARBIT;
        S_READ:  if (rd_end_flag || tout_hit) state <= S_ARBIT;
        default: state <= S_INIT;
      endcase
    end
  end

  // pins follow the owner with no added latency; held at NOP while in reset
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    if (!rst) begin
      case (state)
        S_INIT: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        S_AREF: begin
          sdram_cmd  = ref_cmd;
          sdram_addr = A10_ADDR;
        end
        S_WRITE: begin
          sdram_cmd  = wr_cmd;
          sdram_addr = wr_addr;
          sdram_ba   = wr_bank_addr;
        end
        S_READ: begin
          sdram_cmd  = rd_cmd;
          sdram_addr = rd_addr;
          sdram_ba   = rd_bank_addr;
        end
        default: ;
      endcase
      if (tout_hit) begin
        sdram_cmd  = CMD_PREGE;
        sdram_addr = A10_ADDR;
        sdram_ba   = '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: transaction-level owner model checked every cycle plus directed literals.
module tb_sdram_arbiter;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TOUT = 16;
  localparam bit TOUT_ON = 1'b1;
`else
  localparam int TOUT = 1023;
  localparam bit TOUT_ON = 1'b0;
`endif

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                         WR = 4'b0100, PRE = 4'b0010, AREF = 4'b0001;

  logic clk = 1'b0, rst = 1'b1;
  logic init_end = 0;
  logic [3:0] init_cmd = NOP, ref_cmd = NOP, wr_cmd = NOP, rd_cmd = NOP;
  logic [11:0] init_addr = 0, wr_addr = 0, rd_addr = 0;
  logic [1:0] wr_bank_addr = 0, rd_bank_addr = 0;
  logic ref_rq = 0, ref_end = 0, wr_rq = 0, wr_end_flag = 0, rd_rq = 0, rd_end_flag = 0;
  logic ref_en, wr_en, rd_en, arb_busy;
  logic [3:0] sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0] sdram_ba;
  logic arb_tout_w;

  always #5 clk = ~clk;

  sdram_arbiter #(.TOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_rq(ref_rq), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_en(ref_en),
    .wr_rq(wr_rq), .wr_end_flag(wr_end_flag), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_bank_addr(wr_bank_addr), .wr_en(wr_en),
    .rd_rq(rd_rq), .rd_end_flag(rd_end_flag), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .rd_bank_addr(rd_bank_addr), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba), .arb_busy(arb_busy)
`ifdef SDRAM_ARB_TIMEOUT_EN
    , .arb_tout(arb_tout_w)
`endif
  );

`ifndef SDRAM_ARB_TIMEOUT_EN
  assign arb_tout_w = 1'b0;
`endif

  int pass = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
  endtask

  // Model: who owns the bus (none/init/arbit/ref/wr/rd), which grant is pulsing,
  // how long the current owner has held the bus, and the sticky timeout.
  typedef enum int {O_INIT, O_ARB, O_REF, O_WR, O_RD} owner_e;
  owner_e m_own = O_INIT;
  owner_e m_gnt = O_INIT;
  int m_held = 0;
  bit m_tout = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_own = O_INIT; m_gnt = O_INIT; m_held = 0; m_tout = 0;
    end else begin
      m_gnt = O_INIT;
      if (m_own == O_INIT) begin
        if (init_end) m_own = O_ARB;
      end else if (m_own == O_ARB) begin
        m_held = 0;
        if (ref_rq)     begin m_own = O_REF; m_gnt = O_REF; end
        else if (wr_rq) begin m_own = O_WR;  m_gnt = O_WR;  end
        else if (rd_rq) begin m_own = O_RD;  m_gnt = O_RD;  end
      end else begin
        bit done, hit;
        done = (m_own == O_REF && ref_end) || (m_own == O_WR && wr_end_flag) ||
               (m_own == O_RD && rd_end_flag);
        hit = TOUT_ON && (m_held == TOUT);
        if (hit) m_tout = 1;
        if (done || hit) m_own = O_ARB;
        else m_held++;
      end
    end
    #1;
    begin
      logic [3:0] ec; logic [11:0] ea; logic [1:0] eb;
      ec = NOP; ea = 0; eb = 0;
      if (!rst) begin
        if (m_own == O_INIT) begin ec = init_cmd; ea = init_addr; end
        else if (m_own == O_REF) begin ec = ref_cmd; ea = 12'h400; end
        else if (m_own == O_WR) begin ec = wr_cmd; ea = wr_addr; eb = wr_bank_addr; end
        else if (m_own == O_RD) begin ec = rd_cmd; ea = rd_addr; eb = rd_bank_addr; end
        if (m_own >= O_REF && TOUT_ON && m_held == TOUT) begin ec = PRE; ea = 12'h400; eb = 0; end
      end
      chk("m_cmd", sdram_cmd, ec);
      chk("m_addr", sdram_addr, ea);
      chk("m_ba", sdram_ba, eb);
      chk("m_ref_en", ref_en, (!rst && m_gnt == O_REF));
      chk("m_wr_en", wr_en, (!rst && m_gnt == O_WR));
      chk("m_rd_en", rd_en, (!rst && m_gnt == O_RD));
      chk("m_busy", arb_busy, (m_own >= O_REF));
      chk("m_tout", arb_tout_w, m_tout);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tick(3);
    chk("rst_cmd", sdram_cmd, NOP);
    chk("rst_busy", arb_busy, 0);
    rst = 0;
    // init phase, 20 cycles with a walking init command
    for (int i = 0; i < 20; i++) begin
      init_cmd = 4'(i); init_addr = 12'(i * 3);
      if (i == 7) begin
        #1;
        chk("init_track_cmd", sdram_cmd, 4'h7);
        chk("init_track_addr", sdram_addr, 12'h015);
        chk("init_no_gnt", {ref_en, wr_en, rd_en}, 0);
      end
      tick();
    end
    init_cmd = NOP; init_addr = 0; init_end = 1;
    tick();
    chk("arbit_after_init", sdram_cmd, NOP);
    chk("arbit_idle_busy", arb_busy, 0);
    tick(2);

    // simultaneous requests: ref, then wr, then rd
    ref_cmd = AREF; wr_cmd = WR; wr_addr = 12'h0a5; wr_bank_addr = 2'd2;
    rd_cmd = ACT; rd_addr = 12'h005; rd_bank_addr = 2'd0;
    ref_rq = 1; wr_rq = 1; rd_rq = 1;
    tick();
    chk("ref_en_hi", ref_en, 1);
    chk("ref_wr_lo", wr_en, 0);
    chk("ref_addr", sdram_addr, 12'h400);
    chk("ref_cmd", sdram_cmd, AREF);
    ref_rq = 0;
    tick();
    chk("ref_en_1cyc", ref_en, 0);
    tick(2);
    ref_end = 1; tick(); ref_end = 0;
    chk("gap_arbit", sdram_cmd, NOP);
    chk("gap_no_wr", wr_en, 0);
    tick();
    chk("wr_en_hi", wr_en, 1);
    chk("wr_ba", sdram_ba, 2'd2);
    wr_rq = 0;
    tick(3);
    wr_end_flag = 1; tick(); wr_end_flag = 0;
    tick();
    chk("rd_en_hi", rd_en, 1);
    chk("rd_act", sdram_cmd, ACT);
    chk("rd_addr", sdram_addr, 12'h005);
    rd_rq = 0;
    rd_cmd = RD; #1;
    chk("rd_read_same_cyc", sdram_cmd, RD);
    tick();
    chk("rd_en_1cyc", rd_en, 0);
    rd_cmd = PRE; #1;
    chk("rd_prege", sdram_cmd, PRE);
    tick();
    rd_end_flag = 1; tick(); rd_end_flag = 0; rd_cmd = NOP;
    tick();

    // foreign end flag and late request during a write
    wr_rq = 1; tick(); wr_rq = 0;
    chk("wr2_en", wr_en, 1);
    rd_end_flag = 1; ref_rq = 1; tick(); rd_end_flag = 0;
    chk("wr2_hold_busy", arb_busy, 1);
    chk("wr2_hold_cmd", sdram_cmd, WR);
    tick(3);
    chk("wr2_no_ref", ref_en, 0);
    wr_end_flag = 1; tick(); wr_end_flag = 0;
    chk("wr2_back_arbit", arb_busy, 0);
    tick();
    chk("ref2_en", ref_en, 1);
    ref_rq = 0;
    tick();
    ref_end = 1; tick(); ref_end = 0;
    tick();

    // reset during a read
    rd_rq = 1; rd_cmd = RD; tick(); rd_rq = 0;
    chk("rd3_en", rd_en, 1);
    tick();
    rst = 1; init_end = 0; init_cmd = PRE; #1;
    chk("mid_rst_cmd", sdram_cmd, NOP);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_busy", arb_busy, 0);
    tick(); rst = 0;
    tick();
    chk("post_rst_init_cmd", sdram_cmd, PRE);
    chk("post_rst_busy", arb_busy, 0);
    init_cmd = NOP; init_end = 1;
    tick(2);

`ifdef SDRAM_ARB_TIMEOUT_EN
    begin
      int n;
      wr_cmd = WR; wr_rq = 1; tick(); wr_rq = 0;
      chk("to_wr_en", wr_en, 1);
      n = 0;
      while (n < 40 && sdram_cmd != PRE) begin tick(); n++; end
      chk("to_cycles", n, TOUT);
      chk("to_addr", sdram_addr, 12'h400);
      chk("to_tout_pre", arb_tout_w, 0);
      tick();
      chk("to_tout_set", arb_tout_w, 1);
      chk("to_back_arbit", arb_busy, 0);
      tick(3);
      chk("to_sticky", arb_tout_w, 1);
    end
`endif

    tick(2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
